// File: rtl/aesa_radar_pll_pkg.sv
// Shared types and helpers for the radar PLL reset/lock sequencer.
package aesa_radar_pll_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABILIZE = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } pll_ctrl_state_t;

    // Counter width able to hold (max cycle parameter - 1); never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/aesa_radar_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous bit; clears to 0 on reset.
module aesa_radar_sync_bit #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/aesa_radar_pll_ctrl.sv
// Reset and lock sequencer for the 50 MHz -> 20 MHz radar PLL.
// Define AESA_PLL_CTRL_AUTO_RELOCK_EN to relock automatically on loss of lock in RUN.
module aesa_radar_pll_ctrl
    import aesa_radar_pll_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES     = 50,
    parameter int unsigned LOCK_TIMEOUT       = 50000,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES        = 3,
    parameter int unsigned SYNC_STAGES        = 2,
    localparam int unsigned RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               pll_locked,
    input  logic               sw_relock,
    output logic               pll_rst,
    output logic               ready,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [STATE_W-1:0] state
);

    localparam int unsigned CNT_W = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE_CYCLES);
    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

    logic            locked_s;
    pll_ctrl_state_t state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic pll_rst_q, pll_rst_d;
    logic ready_q, ready_d;
    logic fault_q, fault_d;
    logic fail;

    aesa_radar_sync_bit #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (pll_locked),
        .q       (locked_s)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= RESET_PLL;
            cnt_q     <= '0;
            retry_q   <= '0;
            pll_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            pll_rst_q <= pll_rst_d;
            ready_q   <= ready_d;
            fault_q   <= fault_d;
        end
    end

    // Next state: sw_relock beats a failing attempt, which beats lock progress.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        fail    = 1'b0;
        cnt_d   = ((state_q == RUN) || (state_q == FAULT)) ? cnt_q : cnt_q + CNT_W'(1);

        if (sw_relock) begin
            state_d = RESET_PLL;
            retry_d = '0;
        end else begin
            unique case (state_q)
                RESET_PLL: begin
                    if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (cnt_q == TIMEOUT_LAST) fail = 1'b1;
                    else if (locked_s)         state_d = STABILIZE;
                end
                STABILIZE: begin
                    if (!locked_s) begin
                        fail = 1'b1;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = RUN;
                        retry_d = '0;
                    end
                end
                RUN: begin
                    if (!locked_s) begin
`ifdef AESA_PLL_CTRL_AUTO_RELOCK_EN
                        state_d = RESET_PLL;
                        retry_d = '0;
`else
                        state_d = FAULT;
`endif
                    end
                end
                FAULT: begin
                    state_d = FAULT;
                end
                default: begin
                    state_d = RESET_PLL;
                end
            endcase

            if (fail) begin
                if (retry_q < RETRY_MAX) begin
                    retry_d = retry_q + RETRY_W'(1);
                    state_d = RESET_PLL;
                end else begin
                    state_d = FAULT;
                end
            end
        end

        // Every transition, and any relock, starts the shared counter afresh.
        if (sw_relock || (state_d != state_q)) cnt_d = '0;

        pll_rst_d = (state_d == RESET_PLL) || (state_d == FAULT);
        ready_d   = (state_d == RUN);
        fault_d   = (state_d == FAULT);
    end

    assign pll_rst   = pll_rst_q;
    assign ready     = ready_q;
    assign fault     = fault_q;
    assign retry_cnt = retry_q;
    assign state     = state_q;

endmodule

// File: tb/tb_aesa_radar_pll_ctrl.sv
// Self-checking bench for aesa_radar_pll_ctrl: directed scenarios plus random lock/relock/reset traffic
// compared every cycle against a phase-timing reference model.
module tb_aesa_radar_pll_ctrl;

    localparam int PRC = 4;
    localparam int TO  = 20;
    localparam int LSC = 8;
    localparam int MR  = 2;
    localparam int SS  = 2;
    localparam int RW  = $clog2(MR + 1);

    localparam int P_RST   = 0;
    localparam int P_WAIT  = 1;
    localparam int P_STAB  = 2;
    localparam int P_RUN   = 3;
    localparam int P_FAULT = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          pll_locked = 1'b0;
    logic          sw_relock = 1'b0;
    logic          pll_rst;
    logic          ready;
    logic          fault;
    logic [RW-1:0] retry_cnt;
    logic [2:0]    state;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #10 clk = ~clk;

    aesa_radar_pll_ctrl #(
        .PLL_RST_CYCLES     (PRC),
        .LOCK_TIMEOUT       (TO),
        .LOCK_STABLE_CYCLES (LSC),
        .MAX_RETRIES        (MR),
        .SYNC_STAGES        (SS)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pll_locked (pll_locked),
        .sw_relock  (sw_relock),
        .pll_rst    (pll_rst),
        .ready      (ready),
        .fault      (fault),
        .retry_cnt  (retry_cnt),
        .state      (state)
    );

    // Reference: each phase is described by when it began (edge number); lock seen by the
    // sequencer at edge n is pll_locked as sampled SS edges earlier.
    int m_phase = 0;
    int m_start = 0;
    int m_retry = 0;
    int edge_no = 0;
    bit lk_hist[$];

    always @(posedge clk) begin : ref_model
        int n, ph, st, rt, age;
        bit ls, fl;
        n  = edge_no + 1;
        ph = m_phase;
        st = m_start;
        rt = m_retry;
        fl = 1'b0;
        age = n - m_start;
        if (!reset_n) begin
            lk_hist.delete();
            for (int i = 0; i < SS; i++) lk_hist.push_back(1'b0);
            ph = P_RST;
            st = n;
            rt = 0;
        end else begin
            ls = lk_hist[lk_hist.size() - SS];
            lk_hist.push_back(pll_locked);
            if (lk_hist.size() > 16) void'(lk_hist.pop_front());
            if (sw_relock) begin
                ph = P_RST;
                st = n;
                rt = 0;
            end else begin
                case (m_phase)
                    P_RST:  if (age == PRC) begin ph = P_WAIT; st = n; end
                    P_WAIT: if (age == TO) fl = 1'b1;
                            else if (ls) begin ph = P_STAB; st = n; end
                    P_STAB: if (!ls) fl = 1'b1;
                            else if (age == LSC) begin ph = P_RUN; st = n; rt = 0; end
                    P_RUN:  if (!ls) begin
`ifdef AESA_PLL_CTRL_AUTO_RELOCK_EN
                                ph = P_RST;
                                rt = 0;
`else
                                ph = P_FAULT;
`endif
                                st = n;
                            end
                    default: ;
                endcase
                if (fl) begin
                    st = n;
                    if (rt < MR) begin
                        rt = rt + 1;
                        ph = P_RST;
                    end else begin
                        ph = P_FAULT;
                    end
                end
            end
        end
        edge_no <= n;
        m_phase <= ph;
        m_start <= st;
        m_retry <= rt;
    end

    task automatic check(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_no);
        end
    endtask

    // Advance one cycle and compare all outputs against the reference.
    task automatic tick();
        @(negedge clk);
        if (chk_en) begin
            check("state",     32'(state),     m_phase);
            check("pll_rst",   32'(pll_rst),   (m_phase == P_RST || m_phase == P_FAULT) ? 1 : 0);
            check("ready",     32'(ready),     (m_phase == P_RUN) ? 1 : 0);
            check("fault",     32'(fault),     (m_phase == P_FAULT) ? 1 : 0);
            check("retry_cnt", 32'(retry_cnt), m_retry);
        end
    endtask

    task automatic relock_pulse();
        sw_relock = 1'b1;
        tick();
        sw_relock = 1'b0;
    endtask

    task automatic wait_rst_fall(input string name);
        int n;
        n = 0;
        while (pll_rst && n < 100) begin
            tick();
            n++;
        end
        check(name, 32'(pll_rst), 0);
    endtask

    initial begin
        int n, falls, first, rate;
        bit prev;

        // Reset values
        tick();
        chk_en = 1'b1;
        tick();
        tick();
        check("rst_pll_rst", 32'(pll_rst), 1);
        check("rst_state",   32'(state),   0);
        check("rst_ready",   32'(ready),   0);
        check("rst_fault",   32'(fault),   0);
        check("rst_retry",   32'(retry_cnt), 0);

        // Never locks: three attempts of 4+20 cycles, then FAULT
        reset_n = 1'b1;
        n = 0; falls = 0; first = 0; prev = 1'b1;
        do begin
            tick();
            n++;
            if (prev && !pll_rst) begin
                falls++;
                if (falls == 1) first = n;
                check("retry_step", 32'(retry_cnt), falls - 1);
            end
            prev = pll_rst;
        end while (!fault && n < 200);
        check("first_rst_len",  32'(first), 4);
        check("cycles_to_fault", 32'(n), 72);
        check("rst_pulses",     32'(falls), 3);
        check("fault_retry",    32'(retry_cnt), 2);
        check("fault_pll_rst",  32'(pll_rst), 1);
        check("fault_ready",    32'(ready), 0);

        // sw_relock out of FAULT
        relock_pulse();
        check("relock_fault", 32'(fault), 0);
        check("relock_retry", 32'(retry_cnt), 0);
        check("relock_rst",   32'(pll_rst), 1);
        n = 0;
        do begin tick(); n++; end while (pll_rst && n < 100);
        check("relock_rst_len", 32'(n), 4);

        // Nominal lock 5 cycles into WAIT_LOCK
        repeat (5) tick();
        pll_locked = 1'b1;
        tick();
        n = 0;
        do begin tick(); n++; end while (!ready && n < 100);
        check("lock_to_ready", 32'(n), 10);
        check("run_retry",     32'(retry_cnt), 0);

        // Loss of lock in RUN
        pll_locked = 1'b0;
        n = 0;
        do begin tick(); n++; end while (ready && n < 100);
        check("loss_to_unready", 32'(n), 3);
`ifdef AESA_PLL_CTRL_AUTO_RELOCK_EN
        check("loss_auto_rst",   32'(pll_rst), 1);
        check("loss_auto_fault", 32'(fault), 0);
`else
        check("loss_fault",      32'(fault), 1);
        check("loss_fault_rst",  32'(pll_rst), 1);
`endif

        // Glitch during STABILIZE: one retry, then RUN with retry cleared
        relock_pulse();
        wait_rst_fall("glitch_rst_fall");
        pll_locked = 1'b1;
        repeat (5) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        n = 0;
        do begin tick(); n++; end while (retry_cnt != 1 && n < 50);
        check("glitch_fail_lat", 32'(n), 2);
        check("glitch_retry",    32'(retry_cnt), 1);
        n = 0;
        do begin tick(); n++; end while (pll_rst && n < 50);
        check("glitch_rst_len",  32'(n), 4);
        n = 0;
        while (!ready && n < 100) begin tick(); n++; end
        check("glitch_ready",    32'(ready), 1);
        check("glitch_run_retry", 32'(retry_cnt), 0);

        // sw_relock on the timeout cycle wins over the retry increment
        pll_locked = 1'b0;
        relock_pulse();
        wait_rst_fall("prio_rst_fall");
        repeat (19) tick();
        relock_pulse();
        check("prio_retry", 32'(retry_cnt), 0);
        check("prio_rst",   32'(pll_rst), 1);
        check("prio_state", 32'(state), 0);

        // Reset asserted during STABILIZE
        wait_rst_fall("mid_rst_fall");
        pll_locked = 1'b1;
        n = 0;
        while (state != 3'd2 && n < 50) begin tick(); n++; end
        check("mid_in_stab", 32'(state), 2);
        tick();
        reset_n = 1'b0;
        tick();
        check("mid_rst_pll_rst", 32'(pll_rst), 1);
        check("mid_rst_ready",   32'(ready), 0);
        check("mid_rst_state",   32'(state), 0);
        reset_n = 1'b1;

        // Random lock behaviour, relock requests and resets
        rate = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) rate = int'($urandom_range(3));
            case (rate)
                0: ;
                1: if ($urandom_range(99) == 0) pll_locked = ~pll_locked;
                2: if ($urandom_range(99) < 5)  pll_locked = ~pll_locked;
                default: if ($urandom_range(99) < 25) pll_locked = ~pll_locked;
            endcase
            sw_relock = ($urandom_range(119) == 0);
            reset_n   = ($urandom_range(399) != 0);
            tick();
        end
        sw_relock = 1'b0;
        reset_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aesa_radar_pll_ctrl.md
# aesa_radar_pll_ctrl

Reset and lock sequencer for the HPS-side fabric PLL that derives the 20 MHz radar clock from the 50 MHz reference. Drives the PLL's active-high reset and watches its asynchronous `locked` flag. Declares the derived clock usable (`ready`) only after a stable lock, and retries or faults on lock failure. Sits in the 50 MHz reference domain beside the PLL wrapper; `ready` gates release of the 20 MHz-domain resets.

## Interface
Parameters:
- `PLL_RST_CYCLES`, 50: cycles `pll_rst` is held high per attempt (1 µs at 50 MHz); ≥2.
- `LOCK_TIMEOUT`, 50000: cycles allowed in WAIT_LOCK before the attempt fails (1 ms).
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-locked cycles required before RUN.
- `MAX_RETRIES`, 3: failed attempts tolerated before FAULT.
- `SYNC_STAGES`, 2: synchronizer depth on `pll_locked`; ≥2.

Ports:
- `clk` in 1: 50 MHz reference clock; the block's only clock.
- `reset_n` in 1: synchronous, active-low reset.
- `pll_locked` in 1: PLL lock flag, asynchronous to `clk`.
- `sw_relock` in 1: single-cycle request to restart the sequence.
- `pll_rst` out 1: PLL reset, active high.
- `ready` out 1: derived clock usable.
- `fault` out 1: sticky lock failure.
- `retry_cnt` out $clog2(MAX_RETRIES+1): failed attempts in the current sequence.
- `state` out 3: current FSM state encoding, for debug/CSR.

## Operation
- `pll_locked` passes through SYNC_STAGES flops to give `locked_s`. The FSM uses only `locked_s`.
- All outputs are registered. Reset values: `pll_rst`=1, `ready`=0, `fault`=0, `retry_cnt`=0, `state`=RESET_PLL. One shared cycle counter is cleared on every state transition.
- RESET_PLL (`pll_rst`=1):
  - After PLL_RST_CYCLES cycles, go to WAIT_LOCK.
- WAIT_LOCK (`pll_rst`=0):
  - `locked_s`=1 → STABILIZE.
  - Counter reaches LOCK_TIMEOUT−1 without lock → fail.
- STABILIZE (`pll_rst`=0):
  - `locked_s` stays 1 for LOCK_STABLE_CYCLES consecutive cycles → RUN.
  - Any 0 during the window → fail.
- RUN:
  - `ready`=1; `retry_cnt` cleared on entry.
  - Loss of `locked_s` is handled per Configuration.
- FAULT:
  - `pll_rst`=1, `fault`=1, `ready`=0.
  - Left only via `sw_relock` or reset.
- Fail rule:
  - If `retry_cnt` < MAX_RETRIES: increment `retry_cnt`, go to RESET_PLL.
  - Otherwise go to FAULT; `retry_cnt` holds at MAX_RETRIES.
- `sw_relock`:
  - In any state: go to RESET_PLL with a fresh counter, clear `retry_cnt` and `fault`.
  - In RESET_PLL it restarts the reset pulse.
  - Priority: `sw_relock` > timeout/fail > lock progress, when they occur in the same cycle.
- `reset_n` low mid-sequence aborts immediately to the reset values. The PLL reset reasserts on the next edge.

## Timing
- After `reset_n` rises, `pll_rst` stays high for exactly PLL_RST_CYCLES cycles. It falls on the edge that enters WAIT_LOCK.
- If `pll_locked` rises before edge t:
  - `locked_s`=1 after edge t+SYNC_STAGES−1.
  - STABILIZE is entered at edge t+SYNC_STAGES.
  - `ready` rises LOCK_STABLE_CYCLES edges later.
- In RUN, a `locked_s` drop deasserts `ready` on the next edge, together with the state change.
- `sw_relock` sampled at edge e: `pll_rst`=1 and `ready`=0 from edge e.

## Configuration
- `AESA_PLL_CTRL_AUTO_RELOCK_EN` defined: loss of lock in RUN → RESET_PLL with `retry_cnt` cleared, i.e. a full automatic relock.
- Undefined: loss of lock in RUN → FAULT; software must pulse `sw_relock`.

## Structure
- Package `aesa_radar_pll_pkg`:
  - State enum `pll_ctrl_state_t`: RESET_PLL=0, WAIT_LOCK=1, STABILIZE=2, RUN=3, FAULT=4.
  - Counter width function: $clog2 of the maximum of the three cycle parameters.
- Sub-module `aesa_radar_sync_bit`: parameterized SYNC_STAGES flop chain with synchronous active-low reset to 0. It is reused for other CDC bits.

## Test plan
Bench parameters: PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2, SYNC_STAGES=2.
- Nominal lock: reset release, `pll_locked` rises 5 cycles after `pll_rst` falls and stays high → `pll_rst` high exactly 4 cycles; `ready`=1 exactly 2+8 cycles after the `pll_locked` rise; `retry_cnt`=0.
- Never locks: `pll_locked`=0 throughout → three `pll_rst` pulses, `retry_cnt` steps 0→1→2, then FAULT with `fault`=1, `pll_rst`=1, `ready`=0.
- Glitch in STABILIZE: `locked` high 5 cycles, low 1, then high → `retry_cnt`=1, new 4-cycle `pll_rst` pulse, then RUN with `retry_cnt` cleared.
- Lock loss in RUN: drop `pll_locked` → `ready` falls 3 cycles later. With the macro, a new `pll_rst` pulse and relock; without it, FAULT.
- `sw_relock` recovery:
  - From FAULT: pulse `sw_relock` → `fault`=0, `retry_cnt`=0, `pll_rst` held for exactly 4 cycles.
  - Same-cycle priority: pulse `sw_relock` in the cycle the WAIT_LOCK counter hits 19 → `retry_cnt`=0, not incremented.
- Mid-sequence reset: `reset_n` low during STABILIZE → next edge: `pll_rst`=1, `ready`=0, `state`=0.
